// File: rtl/spi_master.sv
// spi_master: single-clock SPI initiator, mode 0 (SCK idles low, data
// captured on rising SCK, changed on falling SCK), MSB first, fixed width.
//
// Parameters
//   WIDTH    bits per frame (>= 2)
//   CLK_DIV  clk cycles per SCK half-period (>= 1; >= 2 with the macro below)
//
// Configuration macro
//   SPI_MASTER_MISO_SYNC_EN  when defined, spi_miso passes through a 2-flop
//                            synchronizer and is sampled on falling SCK.
//                            Frame timing and bit order are unchanged.
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   start      in   frame request, sampled only in IDLE
//   tx_data    in   word to send, latched on the accept edge
//   busy       out  high from the accept edge until return to IDLE
//   done       out  one-cycle pulse at frame end
//   rx_data    out  received word, updated only with done, then held
//   spi_clk    out  SCK, idles low
//   spi_cs_n   out  chip select, active low, idles high
//   spi_mosi   out  serial data out
//   spi_miso   in   serial data in
//   dbg_state  out  current FSM state (state_t encoding)
//
// Handshake: a frame is accepted on any clock edge where the FSM is IDLE and
// start is 1; busy rises on that edge. start while busy is ignored, never
// queued. done marks rx_data valid for that frame.

module spi_master #(
    parameter int WIDTH   = 32,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             spi_clk,
    output logic             spi_cs_n,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic [2:0]       dbg_state
);

    localparam int CNT_W = $clog2(CLK_DIV) + 1;
    // Bit counter must be able to hold WIDTH itself.
    localparam int BIT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sck_q, sck_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;

    logic             miso_s;
    logic             tick;

`ifdef SPI_MASTER_MISO_SYNC_EN
    // Sampling on falling SCK leaves a full half-period (>= 2 clk) after the
    // rising edge, which covers the two synchronizer stages.
    localparam bit SAMPLE_ON_FALL = 1'b1;

    logic miso_s1_q, miso_s2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            miso_s1_q <= spi_miso;
            miso_s2_q <= miso_s1_q;
        end
    end

    assign miso_s = miso_s2_q;
`else
    localparam bit SAMPLE_ON_FALL = 1'b0;

    assign miso_s = spi_miso;
`endif

    // One half-period elapses when the divider reaches its last count.
    assign tick = (cnt_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sck_d     = sck_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;

        if (state_q != IDLE) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    tx_sr_d = tx_data;
                    rx_sr_d = '0;
                    bit_d   = '0;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    mosi_d  = tx_data[WIDTH-1];
                end
            end

            SETUP: begin
                // End of CS setup: first rising SCK.
                if (tick) begin
                    state_d = SHIFT;
                    sck_d   = 1'b1;
                    if (!SAMPLE_ON_FALL) begin
                        rx_sr_d = {rx_sr_q[WIDTH-2:0], miso_s};
                    end
                end
            end

            SHIFT: begin
                if (tick) begin
                    if (sck_q) begin
                        // Falling SCK: finish bit, present the next one.
                        sck_d = 1'b0;
                        bit_d = bit_q + 1'b1;
                        if (SAMPLE_ON_FALL) begin
                            rx_sr_d = {rx_sr_q[WIDTH-2:0], miso_s};
                        end
                        if (bit_q == BIT_LAST) begin
                            state_d = HOLD;
                            mosi_d  = 1'b0;
                        end else begin
                            tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
                            mosi_d  = tx_sr_q[WIDTH-2];
                        end
                    end else begin
                        sck_d = 1'b1;
                        if (!SAMPLE_ON_FALL) begin
                            rx_sr_d = {rx_sr_q[WIDTH-2:0], miso_s};
                        end
                    end
                end
            end

            HOLD: begin
                if (tick) begin
                    state_d   = GAP;
                    cs_n_d    = 1'b1;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q;
                end
            end

            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sck_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sck_q     <= sck_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rx_data   = rx_data_q;
    assign spi_clk   = sck_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_mosi  = mosi_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master (WIDTH=32). CLK_DIV is 2 by default and
// 4 when SPI_MASTER_MISO_SYNC_EN is defined.

module tb_spi_master;

    localparam int W = 32;
`ifdef SPI_MASTER_MISO_SYNC_EN
    localparam int CD = 4;
`else
    localparam int CD = 2;
`endif
    localparam int LAT    = (2 * W + 1) * CD;
    localparam int BUSY_T = (2 * W + 2) * CD;
    localparam int PERIOD = BUSY_T + 1;
    localparam int BUDGET = PERIOD + 50;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] tx_data;
    logic         busy;
    logic         done;
    logic [W-1:0] rx_data;
    logic         spi_clk;
    logic         spi_cs_n;
    logic         spi_mosi;
    logic         spi_miso;
    logic [2:0]   dbg_state;

    // 0: loopback, 1: tied high, 2: responder model
    int           miso_mode;
    logic [W-1:0] resp_word;
    int           resp_fall;
    logic         resp_bit;

    logic [W-1:0] exp_q[$];
    int           vectors;
    int           miscompares;

    // Monitor state
    int   cyc;
    int   rise_cnt;
    int   rise_outside_cs;
    int   mosi_one_cnt;
    int   done_cnt;
    int   last_done_cyc;
    int   last_cs_fall;
    int   last_cs_rise;
    int   last_cs_gap;
    logic prev_sck;
    logic prev_cs;

    spi_master #(.WIDTH(W), .CLK_DIV(CD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .tx_data   (tx_data),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data),
        .spi_clk   (spi_clk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- MISO sources ----------------
    // Responder: presents bit 0 (MSB) at CS fall, next bit after each falling SCK.
    initial resp_fall = 0;
    always @(negedge spi_clk or posedge spi_cs_n) begin
        if (spi_cs_n) resp_fall <= 0;
        else          resp_fall <= resp_fall + 1;
    end
    always_comb begin
        resp_bit = 1'b0;
        if (resp_fall < W) resp_bit = resp_word[W-1-resp_fall];
    end

    assign spi_miso = (miso_mode == 0) ? spi_mosi :
                      (miso_mode == 1) ? 1'b1 : resp_bit;

    // ---------------- monitor ----------------
    initial begin
        rise_cnt = 0; rise_outside_cs = 0; mosi_one_cnt = 0; done_cnt = 0;
        last_done_cyc = 0; last_cs_fall = 0; last_cs_rise = 0; last_cs_gap = 0;
        prev_sck = 1'b0; prev_cs = 1'b1;
    end

    always @(negedge clk) begin
        prev_sck <= spi_clk;
        prev_cs  <= spi_cs_n;
        if (spi_clk && !prev_sck) begin
            rise_cnt <= rise_cnt + 1;
            if (spi_cs_n) rise_outside_cs <= rise_outside_cs + 1;
        end
        if (spi_mosi) mosi_one_cnt <= mosi_one_cnt + 1;
        if (done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (!spi_cs_n && prev_cs) begin
            last_cs_fall <= cyc;
            last_cs_gap  <= cyc - last_cs_rise;
        end
        if (spi_cs_n && !prev_cs) last_cs_rise <= cyc;
    end

    // ---------------- driver tasks ----------------
    task automatic launch(input logic [W-1:0] word, input bit hold, output int e0);
        @(negedge clk);
        tx_data = word;
        start   = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_done(input int base_cnt, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != base_cnt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({spi_cs_n, spi_clk, spi_mosi, busy, done} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_pins got cs_n,sck,mosi,busy,done=%b want 10000",
                     {spi_cs_n, spi_clk, spi_mosi, busy, done});
        end
        vectors++;
        if (rx_data !== '0) begin
            miscompares++;
            $display("FAIL reset_rx got %h want 0", rx_data);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (dbg_state !== 3'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle got state=%0d busy=%b want 0/0", dbg_state, busy);
        end
    endtask

    task automatic run_frame(input string name, input logic [W-1:0] word,
                             input logic [W-1:0] expect_rx);
        int e0, r0, m0, d0, o0;
        bit ok;
        logic [W-1:0] exp;
        r0 = rise_cnt; m0 = mosi_one_cnt; d0 = done_cnt; o0 = rise_outside_cs;
        exp_q.push_back(expect_rx);
        launch(word, 1'b0, e0);
        wait_done(d0, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s_timeout no done within %0d cycles", name, BUDGET);
            exp_q.delete();
            return;
        end
        exp = exp_q.pop_front();
        vectors++;
        if (rx_data !== exp) begin
            miscompares++;
            $display("FAIL %s_rx got %h want %h", name, rx_data, exp);
        end
        vectors++;
        if (last_done_cyc - e0 !== LAT) begin
            miscompares++;
            $display("FAIL %s_latency got %0d want %0d", name, last_done_cyc - e0, LAT);
        end
        vectors++;
        if (rise_cnt - r0 !== W || rise_outside_cs != o0) begin
            miscompares++;
            $display("FAIL %s_sck_rises got %0d (outside cs %0d) want %0d (0)",
                     name, rise_cnt - r0, rise_outside_cs - o0, W);
        end
        vectors++;
        if (last_cs_rise - last_cs_fall !== LAT) begin
            miscompares++;
            $display("FAIL %s_cs_low got %0d want %0d", name, last_cs_rise - last_cs_fall, LAT);
        end
        if (word == '0) begin
            vectors++;
            if (mosi_one_cnt != m0) begin
                miscompares++;
                $display("FAIL %s_mosi_zero got %0d high cycles want 0", name, mosi_one_cnt - m0);
            end
        end
        // busy falls BUSY_T cycles after E0
        for (int i = 0; i < 4 * CD && busy; i++) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || cyc - e0 !== BUSY_T) begin
            miscompares++;
            $display("FAIL %s_busy_fall got busy=%b at +%0d want 0 at +%0d",
                     name, busy, cyc - e0, BUSY_T);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (rx_data !== exp) begin
            miscompares++;
            $display("FAIL %s_rx_hold got %h want %h", name, rx_data, exp);
        end
    endtask

    task automatic test_loopback();
        miso_mode = 0;
        run_frame("loopback", 32'hA5A50F0F, 32'hA5A50F0F);
    endtask

    task automatic test_miso_ones();
        miso_mode = 1;
        run_frame("miso_ones", 32'h0, 32'hFFFFFFFF);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words[3];
        int dcyc[3];
        int gaps[3];
        int e0, d0;
        bit ok;
        logic [W-1:0] exp;
        miso_mode = 0;
        for (int i = 0; i < 3; i++) words[i] = W'($urandom_range(0, 32'hFFFF_FFFF));
        d0 = done_cnt;
        exp_q.push_back(words[0]);
        launch(words[0], 1'b1, e0);
        for (int i = 0; i < 3; i++) begin
            wait_done(d0 + i, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL b2b_timeout frame %0d", i);
                start = 1'b0;
                exp_q.delete();
                return;
            end
            dcyc[i] = last_done_cyc;
            exp = exp_q.pop_front();
            vectors++;
            if (rx_data !== exp) begin
                miscompares++;
                $display("FAIL b2b_rx frame %0d got %h want %h", i, rx_data, exp);
            end
            if (i < 2) begin
                tx_data = words[i+1];
                exp_q.push_back(words[i+1]);
                if (i == 1) begin
                    // Let the third frame be accepted, then drop start.
                    for (int k = 0; k < BUDGET && busy; k++) @(negedge clk);
                    @(posedge clk);
                    @(negedge clk);
                    start = 1'b0;
                end else begin
                    for (int k = 0; k < BUDGET && busy; k++) @(negedge clk);
                    repeat (2) @(negedge clk);
                end
                gaps[i+1] = last_cs_gap;
            end
        end
        for (int i = 1; i < 3; i++) begin
            vectors++;
            if (dcyc[i] - dcyc[i-1] !== PERIOD) begin
                miscompares++;
                $display("FAIL b2b_spacing %0d got %0d want %0d", i, dcyc[i] - dcyc[i-1], PERIOD);
            end
            vectors++;
            if (gaps[i] !== CD + 1) begin
                miscompares++;
                $display("FAIL b2b_cs_gap %0d got %0d want %0d", i, gaps[i], CD + 1);
            end
        end
        repeat (PERIOD + 10) @(negedge clk);
        vectors++;
        if (done_cnt - d0 !== 3 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_count got %0d frames busy=%b want 3 frames busy=0",
                     done_cnt - d0, busy);
        end
    endtask

    task automatic test_ignore_start();
        int e0, d0;
        bit ok;
        logic [W-1:0] orig;
        logic [W-1:0] exp;
        miso_mode = 0;
        orig = W'($urandom_range(0, 32'hFFFF_FFFF)) | 32'h8000_0001;
        d0 = done_cnt;
        exp_q.push_back(orig);
        launch(orig, 1'b0, e0);
        repeat (4) @(negedge clk);
        tx_data = ~orig;
        repeat (15) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL ignore_timeout no done");
            exp_q.delete();
            return;
        end
        exp = exp_q.pop_front();
        vectors++;
        if (rx_data !== exp) begin
            miscompares++;
            $display("FAIL ignore_rx got %h want %h", rx_data, exp);
        end
        repeat (PERIOD + 20) @(negedge clk);
        vectors++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_count got %0d frames busy=%b want 1 frame busy=0",
                     done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_midframe();
        int e0, d0;
        miso_mode = 0;
        d0 = done_cnt;
        launch(32'hCAFE_F00D, 1'b0, e0);
        while (cyc - e0 < 50) @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({spi_cs_n, spi_clk, spi_mosi, busy, done} !== 5'b10000 || rx_data !== '0) begin
            miscompares++;
            $display("FAIL midreset_pins got cs_n,sck,mosi,busy,done=%b rx=%h want 10000 rx=0",
                     {spi_cs_n, spi_clk, spi_mosi, busy, done}, rx_data);
        end
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (LAT + 10) @(negedge clk);
        vectors++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_no_done got %0d done pulses busy=%b want 0/0",
                     done_cnt - d0, busy);
        end
        run_frame("after_reset", 32'h12345678, 32'h12345678);
    endtask

    task automatic test_responder();
        miso_mode = 2;
        resp_word = 32'hDEADBEEF;
        run_frame("responder", W'($urandom_range(0, 32'hFFFF_FFFF)), 32'hDEADBEEF);
    endtask

    // ---------------- sequence ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        miso_mode   = 0;
        resp_word   = '0;
        start       = 1'b0;
        tx_data     = '0;
        reset_n     = 1'b0;

        test_reset();
        test_loopback();
        wait_idle();
        test_miso_ones();
        wait_idle();
        test_back_to_back();
        wait_idle();
        test_ignore_start();
        wait_idle();
        test_reset_midframe();
        wait_idle();
        test_responder();
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
